cordic_angle_sequencer: RTL
===========================

Name: cordic_angle_sequencer

Overview:
Iteration controller that sits directly upstream of the CORDIC angle adder. It holds the target angle and the running angle accumulator, compares the two, and selects the arctangent constant for the current iteration. It drives the adder's memory operand, direction flags and constant operand, then captures the adder's registered sum back into the accumulator. It also records the per-iteration rotation directions for the downstream X/Y rotators.

Parameters:
W, 6, angle/accumulator width in bits (two's complement, 3 degrees per LSB)
ITERS, 6, maximum CORDIC iterations; must not exceed the atan table depth

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE
target  input  W  requested angle, signed; latched on an accepted start
sum_in  input  W  registered result returned by the adder (1-cycle latency)
ha_mem  output  W  accumulator value driven to the adder
ha_mux  output  W  atan constant for the current iteration
gt  output  1  1 = target > accumulator (adder adds)
lt  output  1  1 = target < accumulator (adder subtracts)
iter  output  3  current iteration index
dirs  output  ITERS  bit i = 1 if iteration i added, 0 if it subtracted
angle_out  output  W  final accumulator value; valid when done=1
busy  output  1  high from the cycle after an accepted start until DONE
done  output  1  single-cycle completion pulse

Behaviour:
- Reset: CLK edge with RST=1 forces state IDLE and clears every output and internal register to 0. This holds mid-run; any in-flight adder result is discarded.
- FSM states:
  - IDLE: start=1 latches target, clears acc, iter and dirs, and goes to CMP. start=0 stays in IDLE.
  - CMP:
    - Signed compare of acc against target.
    - If acc == target or iter == ITERS, go to DONE.
    - Otherwise register ha_mem=acc, ha_mux=ATAN[iter], gt=(target>acc), lt=(target<acc), set dirs[iter]=gt, and go to ADD.
  - ADD: all adder outputs are held stable for one full cycle, so the adder samples them at the closing edge. Go to CAP.
  - CAP: acc <= sum_in, iter <= iter+1, go to CMP.
  - DONE: done=1 and busy=0 for exactly one cycle, angle_out=acc, then go to IDLE.
- Outputs after a run: ha_mem, ha_mux, gt and lt hold their last values outside ADD. gt=lt=0 only after reset. dirs and angle_out hold until the next accepted start.
- Latency: done is high in cycle 3n+2 after the start-sampling edge, where n is the number of iterations executed (0..ITERS).
- Arithmetic:
  - All values are W-bit two's complement; the comparison is signed.
  - The accumulator wraps modulo 2^W with no saturation. With the shipped table it stays within -32..31 for any target in range.
- Boundary cases:
  - Equality at the first CMP (e.g. target=0): finish with n=0 and dirs=0.
  - Early convergence: unused dirs bits stay 0.
  - start while busy: ignored.
  - start in the same cycle as DONE: ignored; it must be reasserted once IDLE is reached.
  - Changes on target after the start is accepted have no effect.

Decomposition:
- Shared package cordic_pkg holds:
  - the W default;
  - the ATAN table as localparam constants in 3-degree units: 15, 9, 5, 2, 1, 1;
  - the state enum IDLE/CMP/ADD/CAP/DONE.
- One sub-module, cordic_atan_rom: a combinational lookup from iter to a W-bit constant. The FSM lives in the top module.

Test Plan:
- target=20, bench adder model returns ha_mem±ha_mux one cycle later -> acc sequence 15, 24, 19, 21, 20; n=5; dirs=6'b001011; angle_out=20; done in cycle 17.
- target=0 -> no ADD cycle ever occurs; done in cycle 2; dirs=0; angle_out=0.
- target=-9 (6'b110111) -> acc sequence -15, -6, -11, -9; dirs=6'b001010; angle_out=-9; done in cycle 14.
- target=7 -> all 6 iterations run (15, 6, 11, 9, 8, 7); dirs=6'b000101; done in cycle 20; angle_out=7.
- RST pulsed in CAP of iteration 2 during the target=31 run -> next cycle state IDLE, busy=0, dirs=0, no done pulse; a fresh start with target=31 then gives dirs=6'b001111, angle_out=31.
- start held high through a run, and start pulsed in the DONE cycle -> exactly one done per accepted start; no second run starts until start is seen in IDLE.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg
// Shared definitions for the CORDIC angle sequencer slice: the default
// angle width, the arctangent table in 3-degree units and the sequencer
// state encoding.
// No ports (package).
package cordic_pkg;

  localparam int CORDIC_W   = 6;
  localparam int ATAN_DEPTH = 6;

  // atan(2^-i) expressed in 3-degree LSBs, rounded
  localparam int ATAN_0 = 15;
  localparam int ATAN_1 = 9;
  localparam int ATAN_2 = 5;
  localparam int ATAN_3 = 2;
  localparam int ATAN_4 = 1;
  localparam int ATAN_5 = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMP  = 3'd1,
    ADD  = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/cordic_angle_sequencer_if.sv
// cordic_angle_sequencer_if
// Operand/result bus between the angle sequencer and the CORDIC angle adder.
//   ha_mem  accumulator operand presented to the adder
//   ha_mux  arctangent constant operand
//   gt, lt  direction flags (gt: add, lt: subtract)
//   sum_in  registered adder result returned to the sequencer
// Modports: master = sequencer side, slave = adder side.
interface cordic_angle_sequencer_if
  import cordic_pkg::*;
#(
  parameter int W = CORDIC_W
);

  logic [W-1:0] ha_mem;
  logic [W-1:0] ha_mux;
  logic         gt;
  logic         lt;
  logic [W-1:0] sum_in;

  modport master (output ha_mem, output ha_mux, output gt, output lt, input sum_in);
  modport slave  (input ha_mem, input ha_mux, input gt, input lt, output sum_in);

endinterface

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom
// Combinational lookup of the arctangent constant for an iteration index.
//   iter  iteration index
//   atan  W-bit constant in 3-degree units (0 beyond the table depth)
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int W = CORDIC_W
) (
  input  logic [2:0]   iter,
  output logic [W-1:0] atan
);

  always_comb begin
    atan = '0;
    case (iter)
      3'd0:    atan = W'(ATAN_0);
      3'd1:    atan = W'(ATAN_1);
      3'd2:    atan = W'(ATAN_2);
      3'd3:    atan = W'(ATAN_3);
      3'd4:    atan = W'(ATAN_4);
      3'd5:    atan = W'(ATAN_5);
      default: atan = '0;
    endcase
  end

endmodule

// File: rtl/cordic_angle_sequencer.sv
// cordic_angle_sequencer
// Iteration controller upstream of the CORDIC angle adder. Holds the target
// and running accumulator, picks the rotation direction each iteration,
// presents operands to the adder and captures its registered sum.
//   CLK, RST   clock and synchronous active-high reset
//   start      begin a run (honoured only in IDLE)
//   target     signed requested angle, latched on an accepted start
//   adder      operand/result bus to the angle adder (master side)
//   iter       current iteration index
//   dirs       bit i set when iteration i added
//   angle_out  final accumulator, valid with done
//   busy       run in progress
//   done       single-cycle completion pulse
// ITERS must not exceed the atan table depth (ATAN_DEPTH).
module cordic_angle_sequencer
  import cordic_pkg::*;
#(
  parameter int W     = CORDIC_W,
  parameter int ITERS = ATAN_DEPTH
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  input  logic [W-1:0]                target,
  cordic_angle_sequencer_if.master    adder,
  output logic [2:0]                  iter,
  output logic [ITERS-1:0]            dirs,
  output logic [W-1:0]                angle_out,
  output logic                        busy,
  output logic                        done
);

  state_e       state;
  logic [W-1:0] target_q;
  logic [W-1:0] acc;
  logic [W-1:0] atan_val;
  logic         target_gt;
  logic         target_lt;
  logic         finished;

  cordic_atan_rom #(.W(W)) u_rom (
    .iter (iter),
    .atan (atan_val)
  );

  assign target_gt = $signed(target_q) > $signed(acc);
  assign target_lt = $signed(target_q) < $signed(acc);
  // Converged, or the iteration budget is spent
  assign finished  = (acc == target_q) || (iter == 3'(ITERS));

  // Adder operands are registered in CMP so they are already stable for the
  // whole ADD cycle; the adder samples them at the edge closing ADD and its
  // result is valid on sum_in during CAP.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      target_q      <= '0;
      acc           <= '0;
      iter          <= '0;
      dirs          <= '0;
      angle_out     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      adder.ha_mem  <= '0;
      adder.ha_mux  <= '0;
      adder.gt      <= 1'b0;
      adder.lt      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            target_q  <= target;
            acc       <= '0;
            iter      <= '0;
            dirs      <= '0;
            angle_out <= '0;
            busy      <= 1'b1;
            state     <= CMP;
          end
        end
        CMP: begin
          if (finished) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            angle_out <= acc;
            state     <= DONE;
          end else begin
            adder.ha_mem <= acc;
            adder.ha_mux <= atan_val;
            adder.gt     <= target_gt;
            adder.lt     <= target_lt;
            if (target_gt) begin
              dirs <= dirs | (ITERS'(1) << iter);
            end
            state <= ADD;
          end
        end
        ADD: begin
          state <= CAP;
        end
        CAP: begin
          acc   <= adder.sum_in;
          iter  <= iter + 3'd1;
          state <= CMP;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
